// File: rtl/result_checker.sv
// result_checker: buffers expected result words in a FIFO, compares them in order against DUT words,
// and reports match/error counts plus the first mismatch of each run.
module result_checker #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  nb_vec_i,
    input  logic              exp_valid_i,
    input  logic [DATA_W-1:0] exp_data_i,
    output logic              exp_ready_o,
    input  logic              dut_valid_i,
    input  logic [DATA_W-1:0] dut_data_i,
    output logic              dut_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  match_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  first_err_idx_o,
    output logic [DATA_W-1:0] first_err_got_o,
    output logic [DATA_W-1:0] first_err_exp_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_nb_vec, r_cmp_cnt, r_match_cnt, r_err_cnt, r_first_idx;
    logic [DATA_W-1:0] r_first_got, r_first_exp;
    logic              w_full, w_empty, w_push, w_pop, w_start, w_match, w_last;
    logic [DATA_W-1:0] w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_empty = r_wptr == r_rptr;
    assign exp_ready_o = (r_state == RUN) && !w_full;
    assign dut_ready_o = (r_state == RUN) && !w_empty;
    assign w_push  = exp_valid_i && exp_ready_o;
    assign w_pop   = dut_valid_i && dut_ready_o;
    assign w_start = start_i && (r_state != RUN);
    assign w_head  = r_mem[r_rptr[AW-1:0]];
    assign w_match = w_head == dut_data_i;
    assign w_last  = (r_cmp_cnt + CNT_W'(1)) == r_nb_vec;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= exp_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_nb_vec    <= '0;
            r_cmp_cnt   <= '0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
        end else if (w_start) begin
            r_state     <= (nb_vec_i == '0) ? DONE : RUN;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_nb_vec    <= nb_vec_i;
            r_cmp_cnt   <= '0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) begin
                r_rptr    <= r_rptr + (AW+1)'(1);
                r_cmp_cnt <= r_cmp_cnt + CNT_W'(1);
                if (w_match) r_match_cnt <= r_match_cnt + CNT_W'(1);
                else if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
                // A zero error count marks the first mismatch; saturation never returns it to zero.
                if (!w_match && r_err_cnt == '0) begin
                    r_first_idx <= r_cmp_cnt;
                    r_first_got <= dut_data_i;
                    r_first_exp <= w_head;
                end
                if (w_last) r_state <= DONE;
            end
        end
    end

    assign busy_o          = r_state == RUN;
    assign done_o          = r_state == DONE;
    assign pass_o          = done_o && (r_err_cnt == '0);
    assign match_cnt_o     = r_match_cnt;
    assign err_cnt_o       = r_err_cnt;
    assign first_err_idx_o = r_first_idx;
    assign first_err_got_o = r_first_got;
    assign first_err_exp_o = r_first_exp;
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: directed scoreboard bench for result_checker with a reference model of the run state.
module tb_result_checker;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] nb_vec = '0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_ready;
    logic          dut_valid = 1'b0;
    logic [DW-1:0] dut_data = '0;
    logic          dut_ready, busy, done, pass;
    logic [CW-1:0] match_cnt, err_cnt, first_idx;
    logic [DW-1:0] first_got, first_exp;

    result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .nb_vec_i(nb_vec),
        .exp_valid_i(exp_valid), .exp_data_i(exp_data), .exp_ready_o(exp_ready),
        .dut_valid_i(dut_valid), .dut_data_i(dut_data), .dut_ready_o(dut_ready),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .match_cnt_o(match_cnt), .err_cnt_o(err_cnt), .first_err_idx_o(first_idx),
        .first_err_got_o(first_got), .first_err_exp_o(first_exp)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] q[$];
    logic          m_run = 0, m_done = 0;
    int            m_nb = 0, m_cmp = 0, m_match = 0, m_err = 0, m_fidx = 0;
    logic [DW-1:0] m_fgot = '0, m_fexp = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_cmp = 0; m_match = 0; m_err = 0; m_fidx = 0; m_fgot = '0; m_fexp = '0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_run));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".pass"}, 32'(pass), 32'(m_done && m_err == 0));
        chk({tag, ".match"}, 32'(match_cnt), 32'(m_match));
        chk({tag, ".err"}, 32'(err_cnt), 32'(m_err));
        chk({tag, ".idx"}, 32'(first_idx), 32'(m_fidx));
        chk({tag, ".got"}, 32'(first_got), 32'(m_fgot));
        chk({tag, ".exp"}, 32'(first_exp), 32'(m_fexp));
    endtask

    // One clock with the given handshakes offered; readies are checked against the model first.
    task automatic cyc(input logic ev, input logic [DW-1:0] ed, input logic dv, input logic [DW-1:0] dd,
                       output logic hp, output logic hc);
        logic [DW-1:0] e;
        exp_valid = ev; exp_data = ed; dut_valid = dv; dut_data = dd;
        #1;
        chk("exp_ready", 32'(exp_ready), 32'(m_run && q.size() < DEPTH));
        chk("dut_ready", 32'(dut_ready), 32'(m_run && q.size() > 0));
        hp = ev && exp_ready;
        hc = dv && dut_ready;
        @(posedge clk);
        if (hc) begin
            e = (q.size() > 0) ? q.pop_front() : '0;
            if (dd == e) m_match++;
            else begin
                if (m_err == 0) begin m_fidx = m_cmp; m_fgot = dd; m_fexp = e; end
                m_err++;
            end
            m_cmp++;
            if (m_cmp == m_nb) begin m_run = 0; m_done = 1; end
        end
        if (hp) q.push_back(ed);
        @(negedge clk);
        exp_valid = 0; dut_valid = 0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        logic hp, hc;
        hp = 0;
        for (int k = 0; k < 20 && !hp; k++) cyc(1, d, 0, '0, hp, hc);
        if (!hp) chk("push_timeout", 32'(exp_ready), 32'd1);
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        logic hp, hc;
        hc = 0;
        for (int k = 0; k < 20 && !hc; k++) cyc(0, '0, 1, d, hp, hc);
        if (!hc) chk("send_timeout", 32'(dut_ready), 32'd1);
    endtask

    task automatic do_start(input int n);
        start = 1; nb_vec = CW'(n);
        @(posedge clk);
        if (!m_run) begin
            model_clear();
            m_nb = n; m_run = (n != 0); m_done = (n == 0);
        end
        @(negedge clk);
        start = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk);
        model_clear();
        m_run = 0; m_done = 0; m_nb = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic hp, hc;
        logic [DW-1:0] v3e[3], v3d[3];
        int pi, ci;
        @(negedge clk);
        do_reset();
        check_outs("reset");
        chk("reset.exp_ready", 32'(exp_ready), 32'd0);
        chk("reset.dut_ready", 32'(dut_ready), 32'd0);

        do_start(4);
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        for (int i = 1; i <= 4; i++) send_word(DW'(i));
        check_outs("nominal");
        chk("nominal.match4", 32'(match_cnt), 32'd4);

        do_start(3);
        v3e = '{16'h00AA, 16'h00BB, 16'h00CC};
        v3d = '{16'h00AA, 16'h1234, 16'h00CC};
        for (int i = 0; i < 3; i++) push_word(v3e[i]);
        for (int i = 0; i < 3; i++) send_word(v3d[i]);
        check_outs("mismatch");
        chk("mismatch.got", 32'(first_got), 32'h1234);
        chk("mismatch.exp", 32'(first_exp), 32'h00BB);

        do_start(2);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 16'h0005, hp, hc);
        cyc(1, 16'h0005, 1, 16'h0005, hp, hc);
        chk("stall.same_cycle_pop", 32'(hc), 32'd0);
        cyc(0, '0, 1, 16'h0005, hp, hc);
        push_word(16'h0006);
        send_word(16'h0006);
        check_outs("stall");

        do_start(20);
        for (int i = 0; i < DEPTH; i++) push_word(DW'(16'h1000 + i));
        cyc(1, 16'h1008, 0, '0, hp, hc);
        chk("full.no_push", 32'(hp), 32'd0);
        pi = DEPTH; ci = 0;
        for (int c = 0; c < 600 && m_run; c++) begin
            cyc(pi < 20 && ($urandom_range(3) != 0), DW'(16'h1000 + pi),
                ci < 20 && ($urandom_range(2) != 0), DW'(16'h1000 + ci), hp, hc);
            if (hp) pi++;
            if (hc) ci++;
        end
        check_outs("wrap");
        chk("wrap.match20", 32'(match_cnt), 32'd20);

        do_start(0);
        check_outs("nb0");
        chk("nb0.pass", 32'(pass), 32'd1);

        do_start(3);
        push_word(16'h0031);
        do_start(5);
        check_outs("start_in_run");
        push_word(16'h0032);
        push_word(16'h0033);
        for (int i = 1; i <= 3; i++) send_word(DW'(16'h0030 + i));
        check_outs("start_in_run.end");
        chk("start_in_run.done", 32'(done), 32'd1);

        do_start(4);
        for (int i = 0; i < 4; i++) push_word(DW'(16'h0040 + i));
        send_word(16'h0040);
        send_word(16'h00FF);
        check_outs("midrun");
        do_reset();
        check_outs("abort");
        chk("abort.exp_ready", 32'(exp_ready), 32'd0);
        chk("abort.dut_ready", 32'(dut_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 16, giving the width of compared result words.
REQ-002 The module SHALL expose parameter DEPTH, default 8, giving the expected-value FIFO depth; the value SHALL be a power of two and at least 2.
REQ-003 The module SHALL expose parameter CNT_W, default 16, giving the width of vector counts and indices.
REQ-004 Ports SHALL be, clock and reset first:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_n_i  in  1  synchronous reset, active-low.
- start_i  in  1  one-cycle pulse that begins a check run.
- nb_vec_i  in  CNT_W  number of results to check; sampled on start_i.
- exp_valid_i  in  1  expected word valid (upstream stimulus side).
- exp_data_i  in  DATA_W  expected result word.
- exp_ready_o  out  1  FIFO accepts the expected word.
- dut_valid_i  in  1  DUT result valid (downstream of the DUT).
- dut_data_i  in  DATA_W  DUT result word.
- dut_ready_o  out  1  checker consumes the DUT word.
- busy_o  out  1  run in progress.
- done_o  out  1  run complete; holds until the next start or reset.
- pass_o  out  1  done_o and zero mismatches.
- match_cnt_o  out  CNT_W  number of compared words that matched.
- err_cnt_o  out  CNT_W  number of mismatches, saturating.
- first_err_idx_o  out  CNT_W  index of the first mismatch, counted from 0.
- first_err_got_o  out  DATA_W  DUT word at the first mismatch.
- first_err_exp_o  out  DATA_W  expected word at the first mismatch.

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-006 Transitions SHALL be:
- IDLE, start_i, nb_vec_i>0 -> RUN.
- IDLE, start_i, nb_vec_i=0 -> DONE, with pass_o=1.
- RUN, last compare -> DONE.
- DONE, start_i -> RUN, or -> DONE if nb_vec_i=0.
- start_i SHALL be ignored in RUN.
REQ-007 On every accepted start_i, the block SHALL, on the same edge, clear all counters and first_err_* registers, flush the FIFO and latch nb_vec_i.
REQ-008 exp_ready_o SHALL equal (state==RUN) and FIFO not full; a push occurs when exp_valid_i and exp_ready_o are both high.
REQ-009 dut_ready_o SHALL equal (state==RUN) and FIFO not empty before any push in the current cycle; a word pushed in cycle N SHALL be consumable no earlier than cycle N+1.
REQ-010 A compare occurs when dut_valid_i and dut_ready_o are both high; it SHALL pop the FIFO head and compare that head with dut_data_i for bitwise equality.
REQ-011 Push and pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-012 Read and write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
- Full: addresses equal, MSBs differ.
- Empty: pointers equal.
REQ-013 Counter and first-error updates SHALL become visible on the edge that completes the compare (1-cycle latency).
- Match: match_cnt_o increments.
- Mismatch: err_cnt_o increments, saturating at 2^CNT_W-1.
REQ-014 The first_err_* registers SHALL capture only on the first mismatch of a run, with idx equal to the number of compares already done in that run.
REQ-015 When the compare count reaches the latched nb_vec, the FSM SHALL enter DONE on that same edge.
- done_o=1, busy_o=0 and the final counters are valid in the next cycle.
- Both ready outputs drop to 0.
REQ-016 Expected words left in the FIFO at DONE SHALL be retained until the next start flush; DUT words arriving in IDLE or DONE SHALL be stalled (ready=0), never dropped.
REQ-017 busy_o SHALL equal (state==RUN) and done_o SHALL equal (state==DONE); pass_o SHALL equal done_o and (err_cnt_o==0).

Reset
REQ-018 When rst_n_i=0 at a rising edge, the block SHALL force state IDLE, empty the FIFO and clear all counters and first_err_* registers to 0.
REQ-019 Reset SHALL take priority over start_i and handshakes, and SHALL abort a run mid-operation with no partial results kept.
REQ-020 After reset, every output SHALL be 0.

Verification
REQ-021 Nominal run: start with nb_vec=4, push expected 0x0001..0x0004, return identical DUT words -> match=4, err=0, done=1, pass=1.
REQ-022 Single mismatch: nb_vec=3, expected {0x00AA,0x00BB,0x00CC}, DUT {0x00AA,0x1234,0x00CC} -> err=1, match=2, idx=1, got=0x1234, exp=0x00BB, pass=0.
REQ-023 Backpressure and wrap: DEPTH=8, push 8 words with no DUT traffic -> exp_ready=0 while full; 20 vectors through mixed push/pop -> all matched, no data loss across pointer wrap.
REQ-024 Empty stall: DUT valid asserted before any expected push -> dut_ready=0 until 1 cycle after the first push.
REQ-025 Edge cases:
- nb_vec=0 -> done=1 and pass=1 one cycle after start.
- start during RUN -> ignored.
- rst_n_i=0 mid-run after 2 compares -> all outputs 0 next cycle.
